// File: rtl/rgmii_txc_pkg.sv
// Shared types and default timing constants for the RGMII TX clock sequencer.
package rgmii_txc_pkg;

   // Encoding matches the speed_i pin: 00=10M, 01=100M, 10=1000M, 11=reserved.
   typedef enum logic [1:0] {
      e_10m   = 2'b00,
      e_100m  = 2'b01,
      e_1000m = 2'b10,
      e_rsvd  = 2'b11
   } speed_e;

   // TXC half-period in downsampler phases (two phases per pattern word).
   localparam int half_1000_def_p = 1;
   localparam int half_100_def_p  = 5;
   localparam int half_10_def_p   = 50;

endpackage

// File: rtl/rgmii_txc_pattern.sv
// Combinational pattern generator: maps the phase counter p (always even) and
// the half-period N onto one 2-bit ODDR word plus rising/falling edge flags.
// Macro RGMII_TXC_SHIFT_EN delays TXC by one phase (high for 1 <= q <= N).
module rgmii_txc_pattern #(
   parameter int cnt_width_p = 7
) (
   input  logic [cnt_width_p-1:0] p_i,
   input  logic [cnt_width_p-1:0] half_i,
   output logic [1:0]             word_o,
   output logic                   rise_o,
   output logic                   fall_o
);

   // One extra bit so p+1 and N+1 never overflow.
   logic [cnt_width_p:0] p_w;
   logic [cnt_width_p:0] p1_w;
   logic [cnt_width_p:0] n_w;
`ifdef RGMII_TXC_SHIFT_EN
   logic [cnt_width_p:0] fall_ph;
`endif

   // Evaluate H() for both phases of the word and locate the edges.
   always_comb begin
      p_w  = {1'b0, p_i};
      p1_w = p_w + 1'b1;
      n_w  = {1'b0, half_i};
`ifdef RGMII_TXC_SHIFT_EN
      // Falling edge sits at phase N+1, which wraps to 0 when the period is 2.
      fall_ph = ((n_w + 1'b1) == {half_i, 1'b0}) ? '0 : (n_w + 1'b1);
      word_o  = {(p_w != '0) && (p_w <= n_w), (p1_w <= n_w)};
      rise_o  = (p_w == '0);
      fall_o  = (p_w == fall_ph) || (p1_w == fall_ph);
`else
      word_o  = {(p_w < n_w), (p1_w < n_w)};
      rise_o  = (p_w == '0);
      fall_o  = (p_w == n_w) || (p1_w == n_w);
`endif
   end

endmodule

// File: rtl/rgmii_txc_ctrl.sv
// RGMII TXC sequencer: feeds 2-bit clock patterns to the ODDR downsampler.
// Speed/enable are only sampled at a TXC period boundary (or while parked),
// so TXC never glitches. Optional macro RGMII_TXC_SHIFT_EN shifts TXC by one
// phase (handled entirely in rgmii_txc_pattern).
module rgmii_txc_ctrl
   import rgmii_txc_pkg::*;
#(
   parameter int half_1000_p = half_1000_def_p,
   parameter int half_100_p  = half_100_def_p,
   parameter int half_10_p   = half_10_def_p,
   parameter int cnt_width_p = (2*half_10_p > 1) ? $clog2(2*half_10_p) : 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] speed_i,
   input  logic       en_i,
   input  logic       ready_i,
   output logic [1:0] clk_setting_o,
   output logic       rise_o,
   output logic       fall_o,
   output logic [1:0] speed_o,
   output logic       active_o
);

   localparam int cw = cnt_width_p;

   logic [cw-1:0] p_q, p_d;
   speed_e        speed_q, speed_d;
   logic          active_q, active_d;
   logic [1:0]    setting_q, setting_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   logic [cw:0]   p_inc;
   logic          boundary;
   logic [cw-1:0] half_cur;
   logic [cw-1:0] half_nxt;
   logic [1:0]    pat_word;
   logic          pat_rise;
   logic          pat_fall;

   function automatic logic [cw-1:0] half_of(input speed_e s);
      case (s)
         e_10m:   half_of = cw'(half_10_p);
         e_100m:  half_of = cw'(half_100_p);
         default: half_of = cw'(half_1000_p);
      endcase
   endfunction

   // Counter advance and boundary sampling of speed/enable on each consume.
   always_comb begin
      p_d      = p_q;
      speed_d  = speed_q;
      active_d = active_q;
      half_cur = half_of(speed_q);
      p_inc    = {1'b0, p_q} + 2'd2;
      boundary = !active_q || (p_inc >= {half_cur, 1'b0});
      if (ready_i) begin
         if (boundary) begin
            p_d = '0;
            if (en_i && (speed_i != e_rsvd)) begin
               speed_d  = speed_e'(speed_i);
               active_d = 1'b1;
            end else begin
               active_d = 1'b0;
            end
         end else begin
            p_d = p_inc[cw-1:0];
         end
      end
      half_nxt = half_of(speed_d);
   end

   rgmii_txc_pattern #(
      .cnt_width_p(cw)
   ) u_pattern (
      .p_i   (p_d),
      .half_i(half_nxt),
      .word_o(pat_word),
      .rise_o(pat_rise),
      .fall_o(pat_fall)
   );

   // Next registered word: the pattern at the new counter, or 00 when parked.
   always_comb begin
      setting_d = setting_q;
      rise_d    = rise_q;
      fall_d    = fall_q;
      if (ready_i) begin
         setting_d = active_d ? pat_word : 2'b00;
         rise_d    = active_d & pat_rise;
         fall_d    = active_d & pat_fall;
      end
   end

   // State and output registers; reset parks TXC low immediately.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         p_q       <= '0;
         speed_q   <= e_1000m;
         active_q  <= 1'b0;
         setting_q <= 2'b00;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         p_q       <= p_d;
         speed_q   <= speed_d;
         active_q  <= active_d;
         setting_q <= setting_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign clk_setting_o = setting_q;
   assign rise_o        = rise_q;
   assign fall_o        = fall_q;
   assign speed_o       = speed_q;
   assign active_o      = active_q;

endmodule

// File: tb/tb_rgmii_txc_ctrl.sv
// Scoreboard bench for rgmii_txc_ctrl. Stimulus queues the expected word for
// every consume; a monitor pops and compares after each consuming edge and
// checks that outputs hold on non-consuming edges. Honours RGMII_TXC_SHIFT_EN.
module tb_rgmii_txc_ctrl;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [1:0] speed_i;
   logic       en_i;
   logic       ready_i;
   logic [1:0] clk_setting_o;
   logic       rise_o;
   logic       fall_o;
   logic [1:0] speed_o;
   logic       active_o;

   rgmii_txc_ctrl dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .speed_i      (speed_i),
      .en_i         (en_i),
      .ready_i      (ready_i),
      .clk_setting_o(clk_setting_o),
      .rise_o       (rise_o),
      .fall_o       (fall_o),
      .speed_o      (speed_o),
      .active_o     (active_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [1:0] w;
      logic       r;
      logic       f;
      logic [1:0] s;
      logic       a;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   nword  = 0;

   function automatic exp_t mk(logic [1:0] w, logic r, logic f, logic [1:0] s, logic a);
      exp_t e;
      e.w = w; e.r = r; e.f = f; e.s = s; e.a = a;
      return e;
   endfunction

   function automatic exp_t rst_exp();
      return mk(2'b00, 1'b0, 1'b0, 2'b10, 1'b0);
   endfunction

   function automatic exp_t park(logic [1:0] s);
      return mk(2'b00, 1'b0, 1'b0, s, 1'b0);
   endfunction

`ifdef RGMII_TXC_SHIFT_EN
   function automatic exp_t x1000();
      return mk(2'b01, 1'b1, 1'b1, 2'b10, 1'b1);
   endfunction

   function automatic exp_t x100(int i);
      case (i)
         0:       return mk(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
         1:       return mk(2'b11, 1'b0, 1'b0, 2'b01, 1'b1);
         2:       return mk(2'b11, 1'b0, 1'b0, 2'b01, 1'b1);
         3:       return mk(2'b00, 1'b0, 1'b1, 2'b01, 1'b1);
         default: return mk(2'b00, 1'b0, 1'b0, 2'b01, 1'b1);
      endcase
   endfunction

   function automatic exp_t x10(int i);
      if (i == 0)       return mk(2'b01, 1'b1, 1'b0, 2'b00, 1'b1);
      else if (i < 25)  return mk(2'b11, 1'b0, 1'b0, 2'b00, 1'b1);
      else if (i == 25) return mk(2'b10, 1'b0, 1'b1, 2'b00, 1'b1);
      else              return mk(2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
   endfunction
`else
   function automatic exp_t x1000();
      return mk(2'b10, 1'b1, 1'b1, 2'b10, 1'b1);
   endfunction

   function automatic exp_t x100(int i);
      case (i)
         0:       return mk(2'b11, 1'b1, 1'b0, 2'b01, 1'b1);
         1:       return mk(2'b11, 1'b0, 1'b0, 2'b01, 1'b1);
         2:       return mk(2'b10, 1'b0, 1'b1, 2'b01, 1'b1);
         default: return mk(2'b00, 1'b0, 1'b0, 2'b01, 1'b1);
      endcase
   endfunction

   function automatic exp_t x10(int i);
      if (i < 25) return mk(2'b11, (i == 0), 1'b0, 2'b00, 1'b1);
      else        return mk(2'b00, 1'b0, (i == 25), 2'b00, 1'b1);
   endfunction
`endif

   task automatic chk(string nm, int act, int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic chk_word(string nm, exp_t req);
      exp_t act;
      act = {clk_setting_o, rise_o, fall_o, speed_o, active_o};
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s #%0d actual{w,r,f,s,a}=%b required=%b", nm, nword, act, req);
      end
   endtask

   task automatic chk_reset(string nm);
      chk({nm, "_setting"}, int'(clk_setting_o), 0);
      chk({nm, "_rise"},    int'(rise_o),        0);
      chk({nm, "_fall"},    int'(fall_o),        0);
      chk({nm, "_speed"},   int'(speed_o),       2);
      chk({nm, "_active"},  int'(active_o),      0);
   endtask

   task automatic consume(exp_t e);
      @(negedge clk_i);
      ready_i = 1'b1;
      q.push_back(e);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      @(negedge clk_i);
      ready_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: compare each presented word against the scoreboard.
   initial begin
      logic cons;
      logic rst_seen;
      exp_t last;
      last = rst_exp();
      forever begin
         @(posedge clk_i);
         cons     = ready_i && !reset_i;
         rst_seen = reset_i;
         #1;
         if (rst_seen) begin
            last = rst_exp();
         end else if (cons) begin
            nword++;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow #%0d actual=empty required=entry", nword);
            end else begin
               last = q.pop_front();
               chk_word("word", last);
            end
         end else begin
            chk_word("hold", last);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1;
      en_i    = 1'b0;
      speed_i = 2'b10;
      ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      reset_i = 1'b0;
      #1;
      chk_reset("reset");
      idle();

      // 1000M with ready toggling
      en_i    = 1'b1;
      speed_i = 2'b10;
      for (int i = 0; i < 6; i++) begin
         consume(x1000());
         idle();
      end

      // 100M, three periods
      speed_i = 2'b01;
      for (int i = 0; i < 15; i++) consume(x100(i % 5));

      // 10M, two periods
      speed_i = 2'b00;
      for (int i = 0; i < 100; i++) consume(x10(i % 50));

      // 100M, then request 1000M on the second word of the period
      speed_i = 2'b01;
      consume(x100(0));
      consume(x100(1));
      speed_i = 2'b10;
      consume(x100(2));
      consume(x100(3));
      consume(x100(4));
      for (int i = 0; i < 3; i++) consume(x1000());

      // 10M, drop enable mid-period, then re-enable
      speed_i = 2'b00;
      for (int i = 0; i < 10; i++) consume(x10(i));
      en_i = 1'b0;
      for (int i = 10; i < 50; i++) consume(x10(i));
      for (int i = 0; i < 3; i++) consume(park(2'b00));
      en_i = 1'b1;
      consume(x10(0));
      consume(x10(1));
      consume(x10(2));

      // reserved speed behaves like disable
      speed_i = 2'b11;
      for (int i = 3; i < 50; i++) consume(x10(i));
      consume(park(2'b00));
      consume(park(2'b00));

      // asynchronous reset in the middle of a 100M period
      speed_i = 2'b01;
      consume(x100(0));
      consume(x100(1));
      #2;
      ready_i = 1'b0;
      reset_i = 1'b1;
      #1;
      chk_reset("async_reset");
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      idle();
      consume(x100(0));
      consume(x100(1));

      repeat (2) idle();
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
